div_unit: RTL and testbench

- Iterative radix-2 divider for the RISC-V M-extension ops div, divu, rem and remu.
- It sits beside the execute-stage ALU, which hands these four ops off and does not compute them combinationally.
- Accepts one operation through a start/busy/done handshake and returns a 32-bit result after a fixed multi-cycle latency.
- Handles the ISA-mandated divide-by-zero and signed-overflow cases on a short path.

---
 rtl/div_unit.sv | 194 +++++++++++++++++++
 tb/tb_div_unit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RISC-V div/divu/rem/remu.
//   clk    - clock, all state updates on the rising edge
//   rst    - synchronous active-high reset, overrides start and kill
//   start  - request, sampled only in IDLE (dropped if kill is also high)
//   op     - 00=div, 01=divu, 10=rem, 11=remu, sampled with start
//   rs1    - dividend, sampled with start
//   rs2    - divisor, sampled with start
//   kill   - abort an in-flight op (CALC or FIX) without a done pulse
//   busy   - high from the edge after acceptance until done is raised
//   done   - one-cycle pulse, result valid
//   result - quotient or remainder, held until the next completion
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic            kill,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = (XLEN > 1) ? $clog2(XLEN) : 1;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [XLEN:0]   rem_q, rem_d;
  logic [XLEN-1:0] quot_q, quot_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            qneg_q, qneg_d;
  logic            rneg_q, rneg_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [XLEN-1:0] result_q, result_d;

  // Operand preparation for the IDLE accept path
  logic            signed_op;
  logic            rs1_neg, rs2_neg;
  logic [XLEN-1:0] rs1_mag, rs2_mag;
  logic            div_zero, ovf;

  // Restoring step datapath
  logic [XLEN:0]   rem_shift, trial;

  // Sign fix-up datapath
  logic [XLEN-1:0] q_fix, r_fix;

  always_comb begin
    signed_op = ~op[0];
    rs1_neg   = signed_op & rs1[XLEN-1];
    rs2_neg   = signed_op & rs2[XLEN-1];
    rs1_mag   = rs1_neg ? (~rs1 + 1'b1) : rs1;
    rs2_mag   = rs2_neg ? (~rs2 + 1'b1) : rs2;
    div_zero  = (rs2 == '0);
    ovf       = signed_op && (rs1 == MIN_NEG) && (rs2 == '1);
  end

  always_comb begin
    // Shift the {rem,quot} pair left by one; the quotient MSB feeds the remainder LSB.
    rem_shift = (rem_q << 1) | {{XLEN{1'b0}}, quot_q[XLEN-1]};
    trial     = rem_shift - {1'b0, dvs_q};
  end

  always_comb begin
    q_fix = qneg_q ? (~quot_q + 1'b1) : quot_q;
    r_fix = rneg_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rem_d    = rem_q;
    quot_d   = quot_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (start && !kill) begin
          op_d   = op;
          busy_d = 1'b1;
          cnt_d  = '0;
          dvs_d  = rs2_mag;
          if (div_zero) begin
            // Final values preloaded; sign flags cleared so FIX passes them through.
            quot_d  = '1;
            rem_d   = {1'b0, rs1};
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIX;
          end else if (ovf) begin
            quot_d  = MIN_NEG;
            rem_d   = '0;
            qneg_d  = 1'b0;
            rneg_d  = 1'b0;
            state_d = FIX;
          end else begin
            // Dividend magnitude starts in the quotient register and shifts out into rem.
            quot_d  = rs1_mag;
            rem_d   = '0;
            qneg_d  = rs1_neg ^ rs2_neg;
            rneg_d  = rs1_neg;
            state_d = CALC;
          end
        end
      end

      CALC: begin
        if (kill) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          if (!trial[XLEN]) begin
            rem_d  = trial;
            quot_d = {quot_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d  = rem_shift;
            quot_d = {quot_q[XLEN-2:0], 1'b0};
          end
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN-1)) begin
            state_d = FIX;
          end
        end
      end

      FIX: begin
        busy_d = 1'b0;
        if (kill) begin
          state_d = IDLE;
        end else begin
          result_d = op_q[1] ? r_fix : q_fix;
          done_d   = 1'b1;
          state_d  = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      rem_q    <= '0;
      quot_q   <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rem_q    <= rem_d;
      quot_q   <= quot_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: scoreboard of expected {result, latency}
// pushed at issue time and popped when done is observed.
module tb_div_unit;

  localparam int unsigned XLEN = 32;
  localparam logic [1:0] OP_DIV = 2'b00, OP_DIVU = 2'b01, OP_REM = 2'b10, OP_REMU = 2'b11;

  logic            clk = 1'b0;
  logic            rst, start, kill;
  logic [1:0]      op;
  logic [XLEN-1:0] rs1, rs2;
  logic            busy, done;
  logic [XLEN-1:0] result;

  typedef struct {
    logic [XLEN-1:0] res;
    int              lat;
  } exp_t;

  exp_t            sb[$];
  int              pass_cnt = 0;
  int              total_cnt = 0;
  logic [XLEN-1:0] last_exp;

  div_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .rs1   (rs1),
    .rs2   (rs2),
    .kill  (kill),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  always #5 clk = ~clk;

  // Reference behaviour written from the ISA rules, independent of the datapath.
  function automatic logic [XLEN-1:0] ref_div(input logic [1:0] o, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
    logic signed [XLEN-1:0] sa, sb_;
    sa  = a;
    sb_ = b;
    if (b == 0) return o[1] ? a : '1;
    if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : 32'h8000_0000;
    case (o)
      OP_DIV:  return sa / sb_;
      OP_DIVU: return a / b;
      OP_REM:  return sa % sb_;
      default: return a % b;
    endcase
  endfunction

  // Drive one request; returns busy sampled just after the accepting edge.
  task automatic issue(input logic [1:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input int lat, output logic busy_after);
    exp_t e;
    e.res = ref_div(o, a, b);
    e.lat = lat;
    @(negedge clk);
    op = o; rs1 = a; rs2 = b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk); #1;
    busy_after = busy;
    start = 1'b0;
    rs1 = $urandom;
    rs2 = $urandom;
    op  = 2'($urandom_range(0, 3));
  endtask

  // Wait (bounded) for done; optionally poke a new start at cycle 'poke'.
  // Also steps one more edge to report whether done was a single-cycle pulse.
  task automatic wait_done(input int poke, output logic [XLEN-1:0] res, output int cyc,
                           output logic next_done);
    cyc = 0;
    res = '0;
    while (cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == poke + 1) start = 1'b0;
      if (done) break;
      if (cyc == poke) begin
        op = OP_DIVU; rs1 = 32'd1000; rs2 = 32'd3; start = 1'b1;
      end
    end
    start = 1'b0;
    res = result;
    @(posedge clk); #1;
    next_done = done;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; kill = 1'b0; op = '0; rs1 = '0; rs2 = '0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else pass_cnt++;
    total_cnt++; if (result !== '0) $display("FAIL reset_result got %h exp 0", result); else pass_cnt++;
    rst = 1'b0;
    last_exp = '0;
  endtask

  // Table-driven run of a list of ops with result, latency, busy and pulse checks.
  task automatic run_table(input string name, input logic [1:0] ops[], input logic [XLEN-1:0] as[],
                           input logic [XLEN-1:0] bs[], input int lats[]);
    logic b, nd;
    logic [XLEN-1:0] r;
    int c;
    exp_t e;
    foreach (ops[i]) begin
      issue(ops[i], as[i], bs[i], lats[i], b);
      wait_done(-10, r, c, nd);
      e = sb.pop_front();
      last_exp = e.res;
      total_cnt++;
      if (r !== e.res) $display("FAIL %s[%0d]_result got %h exp %h", name, i, r, e.res); else pass_cnt++;
      total_cnt++;
      if (c !== e.lat) $display("FAIL %s[%0d]_latency got %0d exp %0d", name, i, c, e.lat); else pass_cnt++;
      total_cnt++;
      if (nd !== 1'b0) $display("FAIL %s[%0d]_done_pulse got %b exp 0", name, i, nd); else pass_cnt++;
      if (e.lat > 1) begin
        total_cnt++;
        if (b !== 1'b1) $display("FAIL %s[%0d]_busy got %b exp 1", name, i, b); else pass_cnt++;
      end
    end
  endtask

  task automatic test_unsigned;
    run_table("unsigned", '{OP_DIVU, OP_REMU}, '{32'd100, 32'd100}, '{32'd7, 32'd7}, '{33, 33});
    total_cnt++;
    if (last_exp !== 32'd2) $display("FAIL remu_model got %h exp 2", last_exp); else pass_cnt++;
  endtask

  task automatic test_signed;
    run_table("signed", '{OP_DIV, OP_REM}, '{32'hFFFF_FFF9, 32'hFFFF_FFF9}, '{32'd2, 32'd2}, '{33, 33});
    total_cnt++;
    if (result !== 32'hFFFF_FFFF) $display("FAIL rem_neg got %h exp ffffffff", result); else pass_cnt++;
  endtask

  task automatic test_div_zero;
    run_table("divzero", '{OP_DIVU, OP_DIV, OP_REMU, OP_REM}, '{32'd5, 32'd5, 32'd5, 32'd5},
              '{32'd0, 32'd0, 32'd0, 32'd0}, '{1, 1, 1, 1});
  endtask

  task automatic test_overflow;
    run_table("overflow", '{OP_DIV, OP_REM}, '{32'h8000_0000, 32'h8000_0000},
              '{32'hFFFF_FFFF, 32'hFFFF_FFFF}, '{1, 1});
  endtask

  task automatic test_random;
    logic [1:0] o[6];
    logic [XLEN-1:0] a[6], b[6];
    int l[6];
    for (int i = 0; i < 6; i++) begin
      o[i] = 2'(i % 4);
      a[i] = $urandom;
      b[i] = (i == 5) ? 32'h0000_0001 : ($urandom >> (i * 4));
      if (b[i] == 0) b[i] = 32'd3;
      l[i] = 33;
    end
    run_table("random", o, a, b, l);
  endtask

  task automatic test_busy_ignore;
    logic b, nd;
    logic [XLEN-1:0] r;
    int c;
    exp_t e;
    issue(OP_DIVU, 32'd100, 32'd7, 33, b);
    wait_done(10, r, c, nd);
    e = sb.pop_front();
    last_exp = e.res;
    total_cnt++;
    if (r !== 32'd14) $display("FAIL busy_ignore_result got %h exp %h", r, 32'd14); else pass_cnt++;
    total_cnt++;
    if (c !== e.lat) $display("FAIL busy_ignore_latency got %0d exp %0d", c, e.lat); else pass_cnt++;
    // The ignored start must not have launched a second operation.
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL busy_ignore_no_queue got %b exp 0", busy); else pass_cnt++;
  endtask

  // Abort at cycle 15 of a div using kill (use_rst=0) or rst (use_rst=1).
  task automatic test_abort(input bit use_rst);
    logic b, nd, seen;
    logic [XLEN-1:0] r, keep;
    int c;
    exp_t e;
    string nm;
    nm = use_rst ? "rst_mid" : "kill_mid";
    keep = use_rst ? '0 : last_exp;
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7, 33, b);
    void'(sb.pop_back());
    repeat (14) @(posedge clk);
    #1;
    if (use_rst) rst = 1'b1; else kill = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; kill = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL %s_busy got %b exp 0", nm, busy); else pass_cnt++;
    seen = done;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL %s_no_done got %b exp 0", nm, seen); else pass_cnt++;
    total_cnt++;
    if (result !== keep) $display("FAIL %s_result_held got %h exp %h", nm, result, keep); else pass_cnt++;
    last_exp = keep;
    issue(OP_DIVU, 32'd9, 32'd3, 33, b);
    wait_done(-10, r, c, nd);
    e = sb.pop_front();
    last_exp = e.res;
    total_cnt++;
    if (r !== 32'd3) $display("FAIL %s_after_result got %h exp 3", nm, r); else pass_cnt++;
    total_cnt++;
    if (c !== e.lat) $display("FAIL %s_after_latency got %0d exp %0d", nm, c, e.lat); else pass_cnt++;
  endtask

  task automatic test_kill_idle;
    @(negedge clk);
    op = OP_DIVU; rs1 = 32'd50; rs2 = 32'd5; start = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; kill = 1'b0;
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL kill_idle_busy got %b exp 0", busy); else pass_cnt++;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++;
    if (done !== 1'b0 || result !== last_exp)
      $display("FAIL kill_idle_quiet got done=%b res=%h exp done=0 res=%h", done, result, last_exp);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_busy_ignore();
    test_abort(1'b0);
    test_abort(1'b1);
    test_kill_idle();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
